prog_loader: RTL and testbench



---
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader.sv | 216 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Stream and memory-write bus for the program loader.
// The master side is the loader: it sinks the byte stream and drives the
// memory write port. The slave side is whoever supplies bytes and receives
// the writes.
interface prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              memWE;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_addr, mem_wdata, memWE
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_addr, mem_wdata, memWE
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: takes a length byte followed by that many data bytes over
// a valid/ready stream and writes them into memory from address 0 upward,
// holding the CPU off the memory port for the duration of the load.
// A length byte of 0 means a full 2^ADDR_W byte image.
// Optional build macro PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte;
// the load is flagged with err when length + data + checksum is nonzero mod 256.
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    prog_loader_if.master     bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t state, next_state;

    logic              in_ready_q,  in_ready_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q,    mem_we_d;
    logic              cpu_hold_q,  cpu_hold_d;
    logic              done_q,      done_d;
    logic [ADDR_W:0]   count_q,     count_d;
    logic [ADDR_W-1:0] len_q,       len_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic              err_q,       err_d;
    logic [DATA_W-1:0] sum_q,       sum_d;
`endif

    // A byte moves only when the registered ready meets the source's valid.
    logic            accept;
    logic [ADDR_W:0] target;
    logic [ADDR_W:0] count_inc;
    logic            last;

    assign accept    = bus.in_valid && in_ready_q;
    assign target    = (len_q == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len_q};
    assign count_inc = count_q + (ADDR_W+1)'(1);
    assign last      = (count_inc == target);

    // State and all output registers; everything is cleared immediately on rst.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            len_q       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            err_q       <= 1'b0;
            sum_q       <= '0;
`endif
        end else begin
            state       <= next_state;
            in_ready_q  <= in_ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            count_q     <= count_d;
            len_q       <= len_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            err_q       <= err_d;
            sum_q       <= sum_d;
`endif
        end
    end

    // Next-state decode: one write cycle per accepted data byte.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start)  next_state = S_LEN;
            S_LEN:   if (accept) next_state = S_DATA;
            S_DATA:  if (accept) next_state = S_WRITE;
            S_WRITE: begin
                if (last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    next_state = S_CSUM;
`else
                    next_state = S_DONE;
`endif
                end else begin
                    next_state = S_DATA;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM:  if (accept) next_state = S_DONE;
`endif
            S_DONE:  if (start)  next_state = S_LEN;
            default: next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath registers.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        in_ready_d  = in_ready_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        count_d     = count_q;
        len_d       = len_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        err_d       = err_q;
        sum_d       = sum_q;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    in_ready_d = 1'b1;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    count_d    = '0;
                    mem_addr_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    err_d      = 1'b0;
`endif
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d = bus.in_data[ADDR_W-1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d = bus.in_data;
`endif
                end
            end
            S_DATA: begin
                if (accept) begin
                    mem_wdata_d = bus.in_data;
                    in_ready_d  = 1'b0;
                    mem_we_d    = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + bus.in_data;
`endif
                end
            end
            S_WRITE: begin
                // Address advances only after the write, so it wraps past the
                // top of memory only once the final byte is stored.
                count_d    = count_inc;
                mem_addr_d = mem_addr_q + ADDR_W'(1);
                if (last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    in_ready_d = 1'b1;
`else
                    in_ready_d = 1'b0;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
`endif
                end else begin
                    in_ready_d = 1'b1;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    in_ready_d = 1'b0;
                    done_d     = 1'b1;
                    // A bad image keeps the CPU held until the next start or rst.
                    if ((sum_q + bus.in_data) == '0) begin
                        err_d      = 1'b0;
                        cpu_hold_d = 1'b0;
                    end else begin
                        err_d      = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.memWE     = mem_we_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign count         = count_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: expected memory writes are queued as bytes are
// driven and compared against each memWE pulse on the falling edge.
module tb_prog_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            cpu_hold;
    logic            done;
    logic            err;
    logic [ADDR_W:0] count;

    prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.master),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_w;
    logic [7:0] img[$];
    int         n_checks = 0;
    int         n_errors = 0;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic       csum_bad = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: each write pulse must match the oldest outstanding byte.
    always @(negedge clk) begin
        if (!rst && bus.memWE) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_w = exp_q.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(mon_w.addr));
                check("wr_data", 32'(bus.mem_wdata), 32'(mon_w.data));
            end
            check("ready_during_write", 32'(bus.in_ready), 32'd0);
        end
    end

    // Present one byte, optionally after idle gaps carrying junk data, and hold
    // it until the loader takes it. Called and returns on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(n < 100), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("done_in_time", 32'(k < 50), 32'd1);
    endtask

    // Stream img (length byte first) and check the end-of-load status.
    // poke_idx >= 1 pulses start while in DATA after that many data bytes.
    task automatic run_load(input int gap, input int poke_idx);
        int         n_exp;
        logic [7:0] addr;
        logic [7:0] sum;
        logic       exp_err;
        wr_t        w;
        n_exp = (img[0] == 8'd0) ? 256 : int'(img[0]);
        addr  = 8'd0;
        sum   = 8'd0;
        for (int i = 0; i < img.size(); i++) begin
            if (i > 0) begin
                w.addr = addr;
                w.data = img[i];
                exp_q.push_back(w);
                addr = addr + 8'd1;
            end
            sum = sum + img[i];
            send_byte(img[i], gap);
            if (i == poke_idx) begin
                @(negedge clk);
                pulse_start();
                check("poke_count", 32'(count), 32'(i));
                check("poke_addr", 32'(bus.mem_addr), 32'(i));
                check("poke_ready", 32'(bus.in_ready), 32'd1);
                check("poke_hold", 32'(cpu_hold), 32'd1);
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        sum = 8'd0 - sum;
        if (csum_bad) sum = sum + 8'd1;
        send_byte(sum, gap);
        exp_err = csum_bad;
`else
        exp_err = 1'b0;
`endif
        wait_done();
        check("done", 32'(done), 32'd1);
        check("count", 32'(count), 32'(n_exp));
        check("err", 32'(err), 32'(exp_err));
        check("cpu_hold_end", 32'(cpu_hold), 32'(exp_err));
        check("ready_in_done", 32'(bus.in_ready), 32'd0);
        check("writes_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #12;
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_we", 32'(bus.memWE), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // start together with a stray byte in IDLE: only start takes effect
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(negedge clk);
        start        = 1'b0;
        bus.in_valid = 1'b0;
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_ready", 32'(bus.in_ready), 32'd1);
        check("start_count", 32'(count), 32'd0);
        check("start_addr", 32'(bus.mem_addr), 32'd0);

        // basic load, valid always presented
        img = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
        run_load(0, -1);

        // restart from DONE with gapped valid
        pulse_start();
        check("restart_done_clr", 32'(done), 32'd0);
        check("restart_ready", 32'(bus.in_ready), 32'd1);
        run_load(2, -1);

        // start during DATA is ignored
        pulse_start();
        img = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load(1, 2);

        // full 256-byte image
        pulse_start();
        img = '{8'h00};
        for (int i = 0; i < 256; i++) img.push_back(8'(i));
        run_load(0, -1);

        // asynchronous reset in the middle of a write
        pulse_start();
        img = '{8'h05, 8'h01, 8'h02};
        for (int i = 0; i < img.size(); i++) begin
            if (i > 0) exp_q.push_back(wr_t'({8'(i - 1), img[i]}));
            send_byte(img[i], 0);
        end
        check("pre_rst_we", 32'(bus.memWE), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(bus.memWE), 32'd0);
        check("mid_rst_hold", 32'(cpu_hold), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_pending", 32'(exp_q.size()), 32'd0);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        pulse_start();
        img = '{8'h03, 8'h5A, 8'hA5, 8'h0F};
        run_load(0, -1);

`ifdef PROG_LOADER_CHECKSUM_EN
        // good checksum 0xCE, then bad checksum 0xCF
        pulse_start();
        img = '{8'h02, 8'h10, 8'h20};
        csum_bad = 1'b0;
        run_load(0, -1);
        pulse_start();
        csum_bad = 1'b1;
        run_load(0, -1);
        pulse_start();
        check("err_clr_on_start", 32'(err), 32'd0);
        check("hold_after_start", 32'(cpu_hold), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
